axil_fifo_rd: RTL and testbench

Parametrised AXI4-lite read-path buffer for AXI-lite interconnect paths. It is the deeper successor to the single-stage read register slice. Both AR and R channels pass through independent FIFOs of configurable depth, and a reservation counter guarantees that every issued read has an R slot waiting. As a result, the R channel never back-pressures the downstream slave.

---
 rtl/axil_fifo_rd_pkg.sv | 13 +
 rtl/axil_fifo_rd_if.sv | 13 +
 rtl/axil_fifo_rd_sync_fifo.sv | 52 +++++
 rtl/axil_fifo_rd.sv | 50 +++++
 tb/tb_axil_fifo_rd.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/axil_fifo_rd_pkg.sv
// axil_defs: shared AXI-lite response codes and width helper
package axil_defs;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/axil_fifo_rd_if.sv
// axil_fifo_rd_if: AXI-lite read channels (AR + R) with master/slave views
interface axil_fifo_rd_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;
   modport master (output araddr, arprot, arvalid, rready, input arready, rdata, rresp, rvalid);
   modport slave  (input araddr, arprot, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/axil_fifo_rd_sync_fifo.sv
// axil_sync_fifo: first-word-fall-through FIFO, no full pass-through or empty bypass
module axil_sync_fifo import axil_defs::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int LW    = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LW-1:0]    level
);
   localparam int AW = clog2(DEPTH);
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d, diff;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             full, empty, push, pop;
   assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty     = wr_q == rd_q;
   assign in_ready  = rst_n & !full;
   assign out_valid = !empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = mem_q[rd_q[AW-1:0]];
   assign diff      = wr_q - rd_q;
   assign level     = LW'(diff);
   // next pointers and storage write
   always_comb begin
      wr_d  = wr_q + {{AW{1'b0}}, push};
      rd_d  = rd_q + {{AW{1'b0}}, pop};
      mem_d = mem_q;
      if (push) mem_d[wr_q[AW-1:0]] = in_data;
   end
   // pointer registers, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   // storage needs no reset: contents are only visible behind valid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/axil_fifo_rd.sv
// axil_fifo_rd: buffered AXI-lite read path with R-slot reservation
module axil_fifo_rd import axil_defs::*; #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int AR_DEPTH   = 4,
   parameter int R_DEPTH    = 4,
   localparam int CW = clog2(((AR_DEPTH > R_DEPTH) ? AR_DEPTH : R_DEPTH) + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   axil_fifo_rd_if.slave         s_axil,
   axil_fifo_rd_if.master        m_axil,
   output logic [CW-1:0]         ar_level,
   output logic [CW-1:0]         r_level,
   output logic [CW-1:0]         rsv_count
);
   logic [ADDR_WIDTH+2:0] ar_out;
   logic [DATA_WIDTH+1:0] r_out;
   logic                  ar_valid, issue_ok, ar_hs, r_hs;
   logic [CW-1:0]         rsv_q, rsv_d;
   // an AR may only leave when an R slot is guaranteed for its answer
   assign issue_ok       = rsv_q < CW'(R_DEPTH);
   assign m_axil.arvalid = ar_valid & issue_ok;
   assign {m_axil.araddr, m_axil.arprot} = ar_out;
   assign {s_axil.rdata, s_axil.rresp}   = r_out;
   assign ar_hs          = m_axil.arvalid & m_axil.arready;
   assign r_hs           = s_axil.rvalid & s_axil.rready;
   assign rsv_count      = rsv_q;
   axil_sync_fifo #(.WIDTH(ADDR_WIDTH + 3), .DEPTH(AR_DEPTH), .LW(CW)) u_ar (
      .clk(clk), .rst_n(rst_n),
      .in_data({s_axil.araddr, s_axil.arprot}), .in_valid(s_axil.arvalid), .in_ready(s_axil.arready),
      .out_data(ar_out), .out_valid(ar_valid), .out_ready(m_axil.arready & issue_ok),
      .level(ar_level)
   );
   axil_sync_fifo #(.WIDTH(DATA_WIDTH + 2), .DEPTH(R_DEPTH), .LW(CW)) u_r (
      .clk(clk), .rst_n(rst_n),
      .in_data({m_axil.rdata, m_axil.rresp}), .in_valid(m_axil.rvalid), .in_ready(m_axil.rready),
      .out_data(r_out), .out_valid(s_axil.rvalid), .out_ready(s_axil.rready),
      .level(r_level)
   );
   // reservation: issued reads plus R data not yet taken upstream
   always_comb begin
      rsv_d = rsv_q + CW'(ar_hs) - CW'(r_hs);
   end
   // reservation register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rsv_q <= '0;
      else        rsv_q <= rsv_d;
   end
endmodule

// File: tb/tb_axil_fifo_rd.sv
// tb_axil_fifo_rd: randomized and directed checks against a queue-based model
module tb_axil_fifo_rd;
   localparam int AD = 4;
   localparam int RD = 4;
   logic clk = 0;
   logic rst_n = 0;
   always #5 clk = ~clk;
   logic [2:0] ar_level, r_level, rsv_count;
   axil_fifo_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
   axil_fifo_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();
   axil_fifo_rd #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .AR_DEPTH(AD), .R_DEPTH(RD)) dut (
      .clk(clk), .rst_n(rst_n), .s_axil(s_if), .m_axil(m_if),
      .ar_level(ar_level), .r_level(r_level), .rsv_count(rsv_count)
   );
   int total = 0;
   int bad = 0;
   int ar_p = 0, mar_p = 0, rv_p = 0, rr_p = 0, ar_left = 0, rsv = 0, pops = 0;
   logic rnd_addr = 0;
   logic [31:0] addr_next = 0;
   logic [31:0] ar_q[$];
   logic [31:0] up_q[$];
   logic [31:0] slv_pend[$];
   logic [33:0] r_q[$];
   function automatic logic [33:0] resp_of(logic [31:0] a);
      return {a ^ 32'hDEADAEEF, a[3:2]};
   endfunction
   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask
   // model: compare DUT outputs, then advance queues by the handshakes of the coming edge
   always @(negedge clk) begin
      logic e_arr, e_marv, e_mrr, e_srv, ap, apop, rpush, rpop;
      if (!rst_n) begin
         chk("rst_arready", s_if.arready, 0);
         chk("rst_marvalid", m_if.arvalid, 0);
         chk("rst_mrready", m_if.rready, 0);
         chk("rst_srvalid", s_if.rvalid, 0);
         chk("rst_levels", {ar_level, r_level, rsv_count}, 0);
         ar_q.delete(); r_q.delete(); up_q.delete(); slv_pend.delete();
         rsv = 0;
      end else begin
         e_arr  = ar_q.size() < AD;
         e_marv = ar_q.size() > 0 && rsv < RD;
         e_mrr  = r_q.size() < RD;
         e_srv  = r_q.size() > 0;
         chk("s_arready", s_if.arready, e_arr);
         chk("m_arvalid", m_if.arvalid, e_marv);
         chk("m_rready", m_if.rready, e_mrr);
         chk("s_rvalid", s_if.rvalid, e_srv);
         chk("ar_level", ar_level, ar_q.size());
         chk("r_level", r_level, r_q.size());
         chk("rsv_count", rsv_count, rsv);
         if (e_marv) chk("m_ar_payload", {m_if.araddr, m_if.arprot}, {ar_q[0], ar_q[0][4:2]});
         if (e_srv) chk("s_r_payload", {s_if.rdata, s_if.rresp}, r_q[0]);
         ap    = s_if.arvalid & e_arr;
         apop  = e_marv & m_if.arready;
         rpush = m_if.rvalid & e_mrr;
         rpop  = e_srv & s_if.rready;
         if (apop) begin
            slv_pend.push_back(ar_q.pop_front());
            rsv++;
         end
         if (ap) begin
            ar_q.push_back(s_if.araddr);
            up_q.push_back(s_if.araddr);
            ar_left--;
            addr_next = rnd_addr ? $urandom : addr_next + 4;
         end
         if (rpop) begin
            chk("in_order", r_q.pop_front(), resp_of(up_q.pop_front()));
            rsv--;
            pops++;
         end
         if (rpush) begin
            void'(slv_pend.pop_front());
            r_q.push_back({m_if.rdata, m_if.rresp});
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
      s_if.arvalid = ar_left > 0 && $urandom_range(99) < ar_p;
      s_if.araddr  = addr_next;
      s_if.arprot  = addr_next[4:2];
      m_if.arready = $urandom_range(99) < mar_p;
      m_if.rvalid  = 0;
      if (slv_pend.size() > 0 && $urandom_range(99) < rv_p) begin
         m_if.rvalid = 1;
         {m_if.rdata, m_if.rresp} = resp_of(slv_pend[0]);
      end
      s_if.rready  = $urandom_range(99) < rr_p;
   endtask
   task automatic set_p(int a, int b, int c, int d);
      ar_p = a; mar_p = b; rv_p = c; rr_p = d;
   endtask
   task automatic drain();
      ar_left = 0;
      set_p(100, 100, 100, 100);
      repeat (20) step();
      chk("drained", {ar_level, r_level, rsv_count}, 0);
   endtask
   task automatic wait_pops(string n, int target, int budget);
      int c = 0;
      while (pops < target && c < budget) begin
         step();
         c++;
      end
      chk(n, pops, target);
   endtask
   initial begin
      int p0, cnt;
      s_if.arvalid = 0; s_if.araddr = 0; s_if.arprot = 0; s_if.rready = 0;
      m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0;
      repeat (3) step();
      rst_n = 1;
      #1;
      chk("post_rst_arready", s_if.arready, 1);
      chk("post_rst_mrready", m_if.rready, 1);
      chk("post_rst_valids", {s_if.rvalid, m_if.arvalid}, 0);
      // single read
      addr_next = 32'h1000; ar_left = 1; set_p(100, 0, 0, 0);
      step(); step();
      chk("single_arvalid", m_if.arvalid, 1);
      chk("single_araddr", m_if.araddr, 32'h1000);
      mar_p = 100;
      step(); step();
      chk("single_rsv1", rsv_count, 1);
      set_p(0, 0, 100, 0);
      step(); step();
      chk("single_rdata", s_if.rdata, 32'hDEADBEEF);
      chk("single_rresp", s_if.rresp, 0);
      rr_p = 100;
      step(); step();
      chk("single_rsv0", rsv_count, 0);
      drain();
      // back-pressure fill and reservation gate
      ar_left = 6; set_p(100, 0, 0, 0);
      repeat (10) step();
      chk("fill_level", ar_level, 4);
      chk("fill_arready", s_if.arready, 0);
      chk("fill_accepted", ar_left, 2);
      set_p(100, 100, 100, 0);
      repeat (12) step();
      chk("gate_rsv", rsv_count, 4);
      chk("gate_arvalid", m_if.arvalid, 0);
      chk("gate_levels", {ar_level, r_level}, {3'd2, 3'd4});
      rr_p = 100;
      step();
      rr_p = 0;
      repeat (8) step();
      chk("gate_one_more", {ar_level, r_level, rsv_count}, {3'd1, 3'd4, 3'd4});
      drain();
      // streaming
      addr_next = 0; ar_left = 64; set_p(100, 100, 100, 100);
      p0 = pops; cnt = 0;
      while (pops - p0 < 64 && cnt < 200) begin
         step();
         cnt++;
      end
      chk("stream_count", pops - p0, 64);
      chk("stream_rate", cnt <= 72, 1);
      drain();
      // random valid/ready
      rnd_addr = 1; ar_left = 1000; set_p(60, 60, 60, 60);
      wait_pops("random_done", pops + 1000, 20000);
      rnd_addr = 0;
      drain();
      // reset mid-burst
      addr_next = 32'h3000; ar_left = 5; set_p(100, 100, 0, 0);
      repeat (3) step();
      mar_p = 0;
      repeat (3) step();
      @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      chk("midrst_readys", {s_if.arready, m_if.rready}, 0);
      chk("midrst_valids", {s_if.rvalid, m_if.arvalid}, 0);
      ar_left = 0; set_p(0, 0, 0, 0);
      repeat (3) step();
      rst_n = 1;
      #1;
      chk("release_levels", {ar_level, r_level, rsv_count}, 0);
      chk("release_arready", s_if.arready, 1);
      addr_next = 32'h2000; ar_left = 1; set_p(100, 100, 100, 100);
      wait_pops("after_rst_read", pops + 1, 30);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
